// File: rtl/huff_pkg.sv
// Shared constants, table-entry record and FSM state type for the Huffman decoder.
package huff_pkg;

   localparam int MAX_CHAR_LENGTH = 5;
   localparam int MAX_CHARS       = MAX_CHAR_LENGTH;
   localparam int CODE_W          = 2 * 6 + 3;
   localparam int LEN_W           = 4;
   localparam int IDX_W           = $clog2(MAX_CHARS);

   typedef struct packed {
      logic [6:0]        ascii_char;
      logic [CODE_W-1:0] code;
      logic [LEN_W-1:0]  len;
   } code_entry_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DECODE,
      ST_OUT,
      ST_DONE,
      ST_ERR
   } dec_state_t;

endpackage

// File: rtl/huff_code_match.sv
// Combinational codeword lookup: compares a candidate prefix against every table entry.
module huff_code_match
   import huff_pkg::*;
(
   input  code_entry_t       tbl [MAX_CHARS],
   input  logic [CODE_W-1:0] cand_code,
   input  logic [LEN_W-1:0]  cand_len,
   output logic              hit,
   output logic [6:0]        hit_char
);

   logic [CODE_W-1:0] mask;

   always_comb begin
      mask     = '0;
      hit      = 1'b0;
      hit_char = '0;
      for (int unsigned b = 0; b < CODE_W; b++) begin
         mask[b] = (LEN_W'(b) < cand_len);
      end
      // Ascending scan with a sticky hit makes the lowest index win.
      for (int unsigned i = 0; i < MAX_CHARS; i++) begin
         if (!hit && (tbl[i].len == cand_len) &&
             (((tbl[i].code ^ cand_code) & mask) == '0)) begin
            hit      = 1'b1;
            hit_char = tbl[i].ascii_char;
         end
      end
   end

endmodule

// File: rtl/huff_decoder.sv
// Serial Huffman decoder: loadable code table, one bit per cycle in, one char out per codeword.
// Optional per-handshake character counter enabled by defining HUFF_DEC_CHAR_CNT_EN.
module huff_decoder
   import huff_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              tbl_wr_en,
   input  logic [IDX_W-1:0]  tbl_wr_idx,
   input  logic [6:0]        tbl_wr_char,
   input  logic [CODE_W-1:0] tbl_wr_code,
   input  logic [LEN_W-1:0]  tbl_wr_len,
   input  logic              start,
   input  logic              bit_in,
   input  logic              bit_valid,
   input  logic              bit_last,
   output logic              bit_ready,
   output logic [6:0]        data_out,
   output logic              data_valid,
   input  logic              data_ready,
   output logic              done,
   output logic              err
`ifdef HUFF_DEC_CHAR_CNT_EN
   ,
   output logic [7:0]        char_cnt
`endif
);

   code_entry_t       tbl [MAX_CHARS];
   dec_state_t        state;
   logic [CODE_W-1:0] acc;
   logic [CODE_W-1:0] cand_code;
   logic [LEN_W-1:0]  len;
   logic [LEN_W-1:0]  cand_len;
   logic              last_q;
   logic              hit;
   logic [6:0]        hit_char;
   logic              start_go;

   assign start_go = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));

   always_comb begin
      cand_code      = acc;
      cand_code[len] = bit_in;
      cand_len       = len + LEN_W'(1);
   end

   huff_code_match u_match (
      .tbl       (tbl),
      .cand_code (cand_code),
      .cand_len  (cand_len),
      .hit       (hit),
      .hit_char  (hit_char)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < MAX_CHARS; i++) begin
            tbl[i] <= '0;
         end
      end else if ((state == ST_IDLE) && tbl_wr_en && (int'(tbl_wr_idx) < MAX_CHARS)) begin
         tbl[tbl_wr_idx] <= '{ascii_char: tbl_wr_char, code: tbl_wr_code, len: tbl_wr_len};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         acc        <= '0;
         len        <= '0;
         last_q     <= 1'b0;
         bit_ready  <= 1'b0;
         data_out   <= '0;
         data_valid <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else if (start_go) begin
         state     <= ST_DECODE;
         acc       <= '0;
         len       <= '0;
         bit_ready <= 1'b1;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         case (state)
            ST_DECODE: begin
               if (bit_valid) begin
                  if (hit) begin
                     data_out   <= hit_char;
                     data_valid <= 1'b1;
                     last_q     <= bit_last;
                     bit_ready  <= 1'b0;
                     state      <= ST_OUT;
                  end else if ((cand_len == LEN_W'(CODE_W)) || bit_last) begin
                     err       <= 1'b1;
                     bit_ready <= 1'b0;
                     state     <= ST_ERR;
                  end else begin
                     acc <= cand_code;
                     len <= cand_len;
                  end
               end
            end
            ST_OUT: begin
               if (data_ready) begin
                  data_valid <= 1'b0;
                  acc        <= '0;
                  len        <= '0;
                  if (last_q) begin
                     done  <= 1'b1;
                     state <= ST_DONE;
                  end else begin
                     bit_ready <= 1'b1;
                     state     <= ST_DECODE;
                  end
               end
            end
            default: ;
         endcase
      end
   end

`ifdef HUFF_DEC_CHAR_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         char_cnt <= '0;
      end else if (start_go) begin
         char_cnt <= '0;
      end else if (data_valid && data_ready && (char_cnt != 8'hFF)) begin
         char_cnt <= char_cnt + 8'd1;
      end
   end
`endif

endmodule
